prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL have port mem_addr  output  DATA_WIDTH  fetch address; stable while a request is outstanding.
REQ-008 SHALL have port mem_rvalid  input  1  memory response valid, one cycle per response.
REQ-009 SHALL have port mem_rdata  input  DATA_WIDTH  fetched instruction word.
REQ-010 SHALL have port redirect  input  1  branch/jump taken in decode (PCSrcD or jumpD).
REQ-011 SHALL have port redirect_pc  input  DATA_WIDTH  new fetch target.
REQ-012 SHALL have port out_valid  output  1  out_instr/out_pc_plus4 hold a valid entry.
REQ-013 SHALL have port out_instr  output  DATA_WIDTH  instruction for the fetch/decode register.
REQ-014 SHALL have port out_pc_plus4  output  DATA_WIDTH  fetch address + 4 of that instruction.
REQ-015 SHALL have port out_ready  input  1  decode accepts entry (driven by ~stallD).

Function
REQ-016 SHALL keep at most one memory request outstanding; mem_req = ~outstanding & (count < DEPTH) & ~redirect.
REQ-017 SHALL treat a request as issued in any cycle mem_req is high; outstanding sets that edge and clears on mem_rvalid.
REQ-018 SHALL drive mem_addr from the fetch-PC register; fetch PC increments by 4 on each accepted (non-discarded) response, modulo 2^DATA_WIDTH.
REQ-019 SHALL push {mem_rdata, fetch PC + 4} into the queue on a non-discarded mem_rvalid.
REQ-020 SHALL pop the head entry on out_valid & out_ready; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-022 SHALL, on redirect, empty the queue (count=0, out_valid low next cycle), load fetch PC with redirect_pc, and deassert mem_req that cycle.
REQ-023 SHALL, when redirect occurs while a request is outstanding or in the same cycle as mem_rvalid, set a discard flag so that response is dropped and fetch PC is not incremented.
REQ-024 SHALL clear the discard flag on the dropped mem_rvalid; a second redirect before then only reloads fetch PC.
REQ-025 SHALL ignore out_ready when out_valid is low; out_instr/out_pc_plus4 are don't-care while out_valid is low.
REQ-026 SHALL never overflow: with count==DEPTH no request is issued, so mem_rvalid cannot arrive when full.

Reset
REQ-027 SHALL on rst asynchronously set fetch PC=RESET_PC, count=0, pointers=0, outstanding=0, discard=0.
REQ-028 SHALL hold mem_req=0 and out_valid=0 while rst is high; mem_addr=RESET_PC and out_instr=0, out_pc_plus4=0 during reset.
REQ-029 SHALL issue the first request (mem_addr=RESET_PC) in the first cycle after rst deasserts; responses to requests issued before reset are not expected.

Configuration
REQ-030 SHALL support macro PREFETCH_BYPASS_EN.
REQ-031 With PREFETCH_BYPASS_EN defined: when the queue is empty and a non-discarded mem_rvalid arrives, out_valid SHALL be high that same cycle with out_instr=mem_rdata; if out_ready is high the entry SHALL not be written to the queue.
REQ-032 Without PREFETCH_BYPASS_EN: responses SHALL always be written to the queue; minimum mem_rvalid-to-out_valid latency is one cycle.

Verification
REQ-033 Reset then 1-cycle-latency memory, out_ready=1: mem_addr sequence 0,4,8,C; out_pc_plus4 4,8,C,10 in order; no gaps beyond one request per two cycles.
REQ-034 out_ready=0 for 10 cycles: exactly DEPTH=4 entries accepted, mem_req low while count==4; releasing out_ready drains 4 entries in 4 consecutive cycles.
REQ-035 Redirect to 0x100 while a request to 0x8 is outstanding: 0x8 response dropped, out_valid low next cycle, next mem_addr=0x100, next out_pc_plus4=0x104.
REQ-036 Redirect in same cycle as mem_rvalid with push and pop active: queue empty afterwards, fetch PC=redirect_pc, no entry emitted from that response.
REQ-037 Assert rst mid-stream with count=3 and outstanding=1: outputs reset immediately without clk edge; after release mem_addr=RESET_PC, out_valid=0 until new response.
REQ-038 Build with and without PREFETCH_BYPASS_EN, queue empty, response 0x2002_0005 arrives: out_valid same cycle (bypass) vs next cycle (no bypass), out_instr=0x2002_0005 in both.

Source files
------------

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch buffer between a single-outstanding instruction memory
// port and the fetch/decode pipeline register. Fetches sequentially from a
// fetch PC, buffers up to DEPTH {instruction, pc+4} entries, and flushes on a
// decode-stage redirect. A response to a request that was in flight when a
// redirect arrived is dropped.
//
// Optional feature (compile-time macro PREFETCH_BYPASS_EN):
//   When defined, a response arriving while the queue is empty is presented
//   on the output in the same cycle; if decode accepts it, it is never written
//   into the queue. When undefined, every response goes through the queue.
//
// Parameters
//   DATA_WIDTH  instruction / address width
//   DEPTH       queue entries (power of two, >= 2)
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   mem_req       fetch request to instruction memory
//   mem_addr      fetch address, stable while a request is outstanding
//   mem_rvalid    memory response valid (one cycle per response)
//   mem_rdata     fetched instruction word
//   redirect      branch/jump taken in decode
//   redirect_pc   new fetch target
//   out_valid     out_instr / out_pc_plus4 hold a valid entry
//   out_instr     instruction for the fetch/decode register
//   out_pc_plus4  fetch address + 4 of that instruction
//   out_ready     decode accepts the entry (~stallD)
// -----------------------------------------------------------------------------
module prefetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  input  logic                  out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // State
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_outstanding;
  logic                  r_discard;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc4   [DEPTH];

  // Next-state and datapath wires
  logic [DATA_WIDTH-1:0] w_fetch_pc_nxt;
  logic                  w_outstanding_nxt;
  logic                  w_discard_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  assign w_pc_plus4 = r_fetch_pc + DATA_WIDTH'(4);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);

  // A response is kept only if it belongs to the current fetch stream: not
  // flagged by an earlier redirect and not coinciding with a redirect now.
  assign w_accept = mem_rvalid & ~r_discard & ~redirect;

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_empty & w_accept;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response that decode takes immediately never occupies a slot.
  assign w_push = w_accept & ~(w_bypass & out_ready);
  assign w_pop  = ~w_empty & out_ready;

  // Memory side: single outstanding request, never issued when full, so a
  // response can never arrive into a full queue.
  assign mem_req  = ~rst & ~r_outstanding & ~w_full & ~redirect;
  assign mem_addr = r_fetch_pc;

  // Decode side
  assign out_valid = ~rst & (~w_empty | w_bypass);

  always_comb begin
    out_instr    = r_instr[r_rd_ptr];
    out_pc_plus4 = r_pc4[r_rd_ptr];
    if (w_bypass) begin
      out_instr    = mem_rdata;
      out_pc_plus4 = w_pc_plus4;
    end
    if (rst) begin
      out_instr    = '0;
      out_pc_plus4 = '0;
    end
  end

  // Next-state logic
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding;
    w_discard_nxt     = r_discard;
    w_count_nxt       = r_count;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_wr_ptr_nxt      = r_wr_ptr;

    if (mem_req) begin
      w_outstanding_nxt = 1'b1;
    end else if (mem_rvalid) begin
      w_outstanding_nxt = 1'b0;
    end

    // Only one request can be in flight, so any response ends the discard
    // window. A redirect on the response cycle drops that response directly
    // and leaves nothing in flight to discard.
    if (mem_rvalid) begin
      w_discard_nxt = 1'b0;
    end else if (redirect && r_outstanding) begin
      w_discard_nxt = 1'b1;
    end

    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
    end else if (w_accept) begin
      w_fetch_pc_nxt = w_pc_plus4;
    end

    if (redirect) begin
      w_count_nxt  = '0;
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_count       <= w_count_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
    end
  end

  // Entry storage; contents are only observed through a valid count, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= mem_rdata;
      r_pc4[r_wr_ptr]   <= w_pc_plus4;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
//
// Self-checking bench for prefetch_queue. A behavioural model keeps the
// expected instruction stream as a queue of {instr, pc+4} words, the next
// expected fetch address, and a simple memory with random latency. Directed
// scenarios plus a randomized run compare the DUT against the model.
// Build with or without +define+PREFETCH_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

  localparam int unsigned DW       = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [DW-1:0] out_pc_plus4;
  logic          out_ready;

  prefetch_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc_plus4 (out_pc_plus4),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fails;

  // Model state
  bit          mem_pending;
  int          mem_lat;
  int          lat_max;
  logic [31:0] mem_paddr;
  bit          drop_pending;
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch;

  // Per-step observations and expectations
  bit          rv_now;
  bit          o_valid, e_valid, o_req, e_req;
  logic [31:0] o_addr, e_addr;
  logic [63:0] o_entry, e_entry;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h2002_0005;
  endfunction

  task automatic model_clear();
    mem_pending  = 1'b0;
    mem_lat      = 0;
    drop_pending = 1'b0;
    exp_q.delete();
    exp_fetch    = RESET_PC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  // One clock of stimulus: drive at negedge, sample combinational outputs
  // just after, then advance the model to what the next posedge commits.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit live, byp;
    @(negedge clk);
    rst         = 1'b0;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    rv_now      = mem_pending && (mem_lat == 0);
    mem_rvalid  = rv_now;
    mem_rdata   = rv_now ? word(mem_paddr) : $urandom;
    #1;
    live    = rv_now && !drop_pending && !redir;
    byp     = BYP && live && (exp_q.size() == 0);
    e_valid = byp || (exp_q.size() != 0);
    if (byp)                  e_entry = {word(exp_fetch), exp_fetch + 32'd4};
    else if (exp_q.size() != 0) e_entry = exp_q[0];
    else                      e_entry = '0;
    e_req   = !mem_pending && (exp_q.size() < int'(DEPTH)) && !redir;
    e_addr  = exp_fetch;
    o_valid = out_valid;
    o_entry = {out_instr, out_pc_plus4};
    o_req   = mem_req;
    o_addr  = mem_addr;

    if (e_valid && rdy && !byp) void'(exp_q.pop_front());
    if (live && !(byp && rdy)) exp_q.push_back({word(exp_fetch), exp_fetch + 32'd4});
    if (live) exp_fetch = exp_fetch + 32'd4;
    if (rv_now) begin
      mem_pending  = 1'b0;
      drop_pending = 1'b0;
    end else if (mem_pending && mem_lat > 0) begin
      mem_lat--;
    end
    if (redir) begin
      if (mem_pending) drop_pending = 1'b1;
      exp_q.delete();
      exp_fetch = rpc;
    end
    if (o_req) begin
      mem_pending = 1'b1;
      mem_paddr   = o_addr;
      mem_lat     = int'($urandom_range(lat_max, 0));
    end
  endtask

  task automatic test_reset();
    do_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    out_ready  = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (mem_addr !== RESET_PC) begin
      n_fails++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, RESET_PC);
    end
    n_checks++;
    if (out_instr !== 32'h0) begin
      n_fails++; $display("FAIL reset_out_instr: got %h expected 0", out_instr);
    end
    n_checks++;
    if (out_pc_plus4 !== 32'h0) begin
      n_fails++; $display("FAIL reset_out_pc_plus4: got %h expected 0", out_pc_plus4);
    end
    lat_max = 0;
    step(1'b1, 1'b0, '0);
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      n_fails++;
      $display("FAIL first_request: got req=%b addr=%h expected req=1 addr=%h",
               o_req, o_addr, RESET_PC);
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fails++; $display("FAIL first_out_valid: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_stream();
    int          req_cyc[$];
    logic [31:0] req_addr[$];
    logic [31:0] pc4s[$];
    do_reset();
    lat_max = 0;
    for (int c = 0; c < 40 && pc4s.size() < 4; c++) begin
      step(1'b1, 1'b0, '0);
      if (o_req) begin
        req_cyc.push_back(c);
        req_addr.push_back(o_addr);
      end
      if (o_valid) pc4s.push_back(o_entry[31:0]);
    end
    n_checks++;
    if (pc4s.size() < 4 || req_addr.size() < 4) begin
      n_fails++;
      $display("FAIL stream_timeout: got %0d outputs %0d requests expected 4 each",
               pc4s.size(), req_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (req_addr[k] !== 32'(4 * k) || req_cyc[k] != 2 * k) begin
          n_fails++;
          $display("FAIL stream_req%0d: got addr=%h cycle=%0d expected addr=%h cycle=%0d",
                   k, req_addr[k], req_cyc[k], 32'(4 * k), 2 * k);
        end
        n_checks++;
        if (pc4s[k] !== 32'(4 * k + 4)) begin
          n_fails++;
          $display("FAIL stream_pc4_%0d: got %h expected %h", k, pc4s[k], 32'(4 * k + 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset();
    lat_max = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, '0);
      if (o_req) nreq++;
      if (c >= 8) begin
        n_checks++;
        if (o_req !== 1'b0) begin
          n_fails++; $display("FAIL full_no_req_c%0d: got %b expected 0", c, o_req);
        end
      end
    end
    n_checks++;
    if (nreq != int'(DEPTH)) begin
      n_fails++; $display("FAIL full_accepted: got %0d expected %0d", nreq, DEPTH);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      n_checks++;
      if (o_valid !== 1'b1 || o_entry[31:0] !== 32'(4 * k + 4)) begin
        n_fails++;
        $display("FAIL drain_%0d: got valid=%b pc4=%h expected valid=1 pc4=%h",
                 k, o_valid, o_entry[31:0], 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit seen;
    do_reset();
    lat_max = 0;
    for (int c = 0; c < 20 && !(mem_pending && mem_paddr == 32'h8); c++) step(1'b0, 1'b0, '0);
    n_checks++;
    if (!(mem_pending && mem_paddr == 32'h8)) begin
      n_fails++; $display("FAIL redir_out_setup: got no request to 8 expected one");
    end
    mem_lat = 2;
    step(1'b1, 1'b1, 32'h100);
    n_checks++;
    if (o_req !== 1'b0) begin
      n_fails++; $display("FAIL redir_out_req_masked: got %b expected 0", o_req);
    end
    step(1'b1, 1'b0, '0);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fails++; $display("FAIL redir_out_flushed: got %b expected 0", o_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1'b1, 1'b0, '0);
      if (o_req) begin
        seen = 1'b1;
        n_checks++;
        if (o_addr !== 32'h100) begin
          n_fails++; $display("FAIL redir_out_next_addr: got %h expected 00000100", o_addr);
        end
      end
      if (o_valid) begin
        n_fails++; n_checks++;
        $display("FAIL redir_out_dropped: got pc4=%h expected no output", o_entry[31:0]);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1'b1, 1'b0, '0);
      if (o_valid) begin
        seen = 1'b1;
        n_checks++;
        if (o_entry !== {word(32'h100), 32'h104}) begin
          n_fails++;
          $display("FAIL redir_out_first_entry: got %h expected %h",
                   o_entry, {word(32'h100), 32'h104});
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fails++; $display("FAIL redir_out_timeout: got no output expected pc4=104");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit seen;
    do_reset();
    lat_max = 0;
    for (int c = 0; c < 20 && !(exp_q.size() >= 2 && mem_pending); c++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h200);
    n_checks++;
    if (o_valid !== 1'b1 || rv_now !== 1'b1) begin
      n_fails++;
      $display("FAIL same_cycle_setup: got valid=%b rvalid=%b expected 1 1", o_valid, rv_now);
    end
    step(1'b1, 1'b0, '0);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fails++; $display("FAIL same_cycle_empty: got %b expected 0", o_valid);
    end
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h200) begin
      n_fails++;
      $display("FAIL same_cycle_fetch: got req=%b addr=%h expected req=1 addr=00000200",
               o_req, o_addr);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1'b1, 1'b0, '0);
      if (o_valid) begin
        seen = 1'b1;
        n_checks++;
        if (o_entry[31:0] !== 32'h204) begin
          n_fails++; $display("FAIL same_cycle_next: got %h expected 00000204", o_entry[31:0]);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fails++; $display("FAIL same_cycle_timeout: got no output expected pc4=204");
    end
  endtask

  task automatic test_bypass();
    do_reset();
    lat_max = 0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (o_valid !== BYP) begin
      n_fails++; $display("FAIL bypass_same_cycle: got %b expected %b", o_valid, BYP);
    end
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (o_valid !== 1'b1 || o_entry !== {32'h2002_0005, 32'h4}) begin
      n_fails++;
      $display("FAIL bypass_entry: got valid=%b entry=%h expected valid=1 entry=2002000500000004",
               o_valid, o_entry);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    lat_max = 0;
    for (int c = 0; c < 20 && !(exp_q.size() == 3 && mem_pending); c++) step(1'b0, 1'b0, '0);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset_ctrl: got req=%b valid=%b expected 0 0", mem_req, out_valid);
    end
    n_checks++;
    if (mem_addr !== RESET_PC || out_instr !== 32'h0 || out_pc_plus4 !== 32'h0) begin
      n_fails++;
      $display("FAIL async_reset_data: got addr=%h instr=%h pc4=%h expected %h 0 0",
               mem_addr, out_instr, out_pc_plus4, RESET_PC);
    end
    model_clear();
    mem_rvalid = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, '0);
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC || o_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset_restart: got req=%b addr=%h valid=%b expected 1 %h 0",
               o_req, o_addr, o_valid, RESET_PC);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b1, 1'b0, '0);
      if (o_valid) begin
        seen = 1'b1;
        n_checks++;
        if (o_entry[31:0] !== RESET_PC + 32'd4) begin
          n_fails++;
          $display("FAIL async_reset_first: got %h expected %h", o_entry[31:0], RESET_PC + 32'd4);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fails++; $display("FAIL async_reset_timeout: got no output expected one");
    end
  endtask

  task automatic test_random();
    bit          rdy, redir;
    logic [31:0] rpc;
    do_reset();
    lat_max = 3;
    for (int c = 0; c < 800; c++) begin
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(19, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      step(rdy, redir, rpc);
      n_checks++;
      if (o_req !== e_req) begin
        n_fails++; $display("FAIL rand_mem_req c%0d: got %b expected %b", c, o_req, e_req);
      end
      if (e_req) begin
        n_checks++;
        if (o_addr !== e_addr) begin
          n_fails++; $display("FAIL rand_mem_addr c%0d: got %h expected %h", c, o_addr, e_addr);
        end
      end
      n_checks++;
      if (o_valid !== e_valid) begin
        n_fails++; $display("FAIL rand_out_valid c%0d: got %b expected %b", c, o_valid, e_valid);
      end
      if (e_valid && o_valid) begin
        n_checks++;
        if (o_entry !== e_entry) begin
          n_fails++; $display("FAIL rand_entry c%0d: got %h expected %h", c, o_entry, e_entry);
        end
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    lat_max     = 0;
    rst         = 1'b1;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_bypass();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
